scan_select: RTL and testbench

SCAN_SELECT -- requirements
Module: scan_select

---
 rtl/scan_select.sv | 82 ++++++++
 tb/tb_scan_select.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_select.sv
// Multiplexed display digit scanner: steps a one-hot digit select through
// DIGITS slots of DIV clocks each, with optional leading blanking per slot.
module scan_select #(
  parameter int DIGITS     = 4,
  parameter int DIV        = 50000,
  parameter int BLANK      = 0,
  parameter int ACTIVE_LOW = 1,
  localparam int IDX_W     = $clog2(DIGITS),
  localparam int CNT_W     = $clog2(DIV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [IDX_W-1:0]  digit_idx,
  output logic [DIGITS-1:0] digit_sel,
  output logic              blank,
  output logic              slot_tick,
  output logic              frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              slot_tick_q, slot_tick_d;
  logic              frame_tick_q, frame_tick_d;
  logic              wrap;
  logic              in_blank;
  logic [DIGITS-1:0] sel_hot;
  logic [DIGITS-1:0] drive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      slot_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      slot_tick_q  <= slot_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Everything holds while en=0, so a wrap blocked by en only happens on resume.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    slot_tick_d  = slot_tick_q;
    frame_tick_d = frame_tick_q;
    wrap         = (cnt_q == CNT_LAST);
    if (en) begin
      cnt_d        = wrap ? '0 : cnt_q + 1'b1;
      slot_tick_d  = wrap;
      frame_tick_d = wrap && (idx_q == IDX_LAST);
      if (wrap) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
  end

  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_q < CNT_W'(BLANK));
    end
  endgenerate

  assign blank     = !rst_n || !en || in_blank;
  assign sel_hot   = DIGITS'(1) << idx_q;
  assign drive     = blank ? '0 : sel_hot;
  assign digit_sel = (ACTIVE_LOW != 0) ? ~drive : drive;
  assign digit_idx = idx_q;

  // A tick held across a freeze becomes visible in the first enabled cycle.
  assign slot_tick  = slot_tick_q & en;
  assign frame_tick = frame_tick_q & en;

endmodule

// File: tb/tb_scan_select.sv
// Bench for scan_select: two configurations, directed scenarios plus random
// enable/reset traffic checked against an enabled-cycle-count model.
module tb_scan_select;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, en_a, blank_a, st_a, ft_a;
  logic [1:0] idx_a;
  logic [3:0] sel_a;
  logic       rst_b_n, en_b, blank_b, st_b, ft_b;
  logic [1:0] idx_b;
  logic [2:0] sel_b;

  int checks = 0;
  int errors = 0;
  int n_a = 0;
  int n_b = 0;

  scan_select #(.DIGITS(4), .DIV(5), .BLANK(1), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .en(en_a), .digit_idx(idx_a), .digit_sel(sel_a),
    .blank(blank_a), .slot_tick(st_a), .frame_tick(ft_a));

  scan_select #(.DIGITS(3), .DIV(2), .BLANK(0), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .en(en_b), .digit_idx(idx_b), .digit_sel(sel_b),
    .blank(blank_b), .slot_tick(st_b), .frame_tick(ft_b));

  // Model: n = enabled cycles since reset; slot = n/div, position = n%div.
  function automatic int m_idx(int n, int div, int dig);
    return (n / div) % dig;
  endfunction
  function automatic logic m_blank(int n, int div, int blk, logic e);
    return !e || ((n % div) < blk);
  endfunction
  function automatic logic m_tick(int n, int div, logic e);
    return e && (n > 0) && ((n % div) == 0);
  endfunction
  function automatic logic m_frame(int n, int div, int dig, logic e);
    return m_tick(n, div, e) && (m_idx(n, div, dig) == 0);
  endfunction
  function automatic logic [7:0] m_sel(int n, int div, int dig, int blk, logic e, logic al);
    logic [7:0] h;
    logic [7:0] mask;
    mask = 8'((1 << dig) - 1);
    h = m_blank(n, div, blk, e) ? 8'h00 : (8'h01 << m_idx(n, div, dig));
    if (al) h = ~h & mask;
    return h;
  endfunction

  // Positioned just after a falling edge: apply enables, let outputs settle.
  task automatic drv(input logic ea, input logic eb);
    en_a = ea;
    en_b = eb;
    #1;
  endtask

  task automatic clk_edge;
    @(posedge clk);
    if (en_a) n_a++;
    if (en_b) n_b++;
    @(negedge clk);
  endtask

  task automatic reset_a;
    rst_a_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    n_a = 0;
  endtask

  task automatic reset_b;
    rst_b_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b_n = 1'b1;
    n_b = 0;
  endtask

  task automatic test_reset;
    rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b1; en_b = 1'b1;
    #3;
    checks++;
    if (sel_a !== 4'hF || blank_a !== 1'b1 || idx_a !== 2'd0 || st_a !== 1'b0 || ft_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a sel=%b blank=%b idx=%0d st=%b ft=%b want sel=1111 blank=1 idx=0 st=0 ft=0",
               sel_a, blank_a, idx_a, st_a, ft_a);
    end
    checks++;
    if (sel_b !== 3'b000 || blank_b !== 1'b1 || idx_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_b sel=%b blank=%b idx=%0d want sel=000 blank=1 idx=0", sel_b, blank_b, idx_b);
    end
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1; n_a = 0; n_b = 0;
  endtask

  task automatic test_first_slot;
    reset_a;
    for (int c = 0; c <= 5; c++) begin
      drv(1'b1, 1'b0);
      checks++;
      if (sel_a !== 4'(m_sel(n_a, 5, 4, 1, 1'b1, 1'b1)) || st_a !== m_tick(n_a, 5, 1'b1)) begin
        errors++;
        $display("FAIL first_slot cyc%0d sel=%b st=%b want sel=%b st=%b", c, sel_a, st_a,
                 4'(m_sel(n_a, 5, 4, 1, 1'b1, 1'b1)), m_tick(n_a, 5, 1'b1));
      end
      if (c == 5) begin
        checks++;
        if (idx_a !== 2'd1 || st_a !== 1'b1 || sel_a !== 4'hF) begin
          errors++;
          $display("FAIL first_slot_c5 idx=%0d st=%b sel=%b want idx=1 st=1 sel=1111", idx_a, st_a, sel_a);
        end
      end
      clk_edge;
    end
  endtask

  task automatic test_frame;
    int st_cnt, ft_cnt, ft_cyc;
    st_cnt = 0; ft_cnt = 0; ft_cyc = -1;
    reset_a;
    for (int c = 0; c <= 20; c++) begin
      drv(1'b1, 1'b0);
      checks++;
      if (idx_a !== 2'(m_idx(n_a, 5, 4)) || ft_a !== m_frame(n_a, 5, 4, 1'b1)) begin
        errors++;
        $display("FAIL frame cyc%0d idx=%0d ft=%b want idx=%0d ft=%b", c, idx_a, ft_a,
                 m_idx(n_a, 5, 4), m_frame(n_a, 5, 4, 1'b1));
      end
      if (c > 0 && st_a) st_cnt++;
      if (ft_a) begin ft_cnt++; ft_cyc = c; end
      clk_edge;
    end
    checks++;
    if (st_cnt != 4 || ft_cnt != 1 || ft_cyc != 20) begin
      errors++;
      $display("FAIL frame_counts slot_ticks=%0d frame_ticks=%0d at=%0d want 4 1 20", st_cnt, ft_cnt, ft_cyc);
    end
  endtask

  task automatic test_freeze;
    logic e;
    reset_a;
    for (int c = 0; c < 12; c++) begin
      e = !(c >= 2 && c <= 4);
      drv(e, 1'b0);
      checks++;
      if (sel_a !== 4'(m_sel(n_a, 5, 4, 1, e, 1'b1)) || blank_a !== m_blank(n_a, 5, 1, e) ||
          st_a !== m_tick(n_a, 5, e) || ft_a !== 1'b0) begin
        errors++;
        $display("FAIL freeze cyc%0d sel=%b blank=%b st=%b ft=%b want sel=%b blank=%b st=%b ft=0", c,
                 sel_a, blank_a, st_a, ft_a, 4'(m_sel(n_a, 5, 4, 1, e, 1'b1)),
                 m_blank(n_a, 5, 1, e), m_tick(n_a, 5, e));
      end
      clk_edge;
    end
  endtask

  task automatic test_async_reset;
    reset_a;
    for (int c = 0; c < 12; c++) begin drv(1'b1, 1'b0); clk_edge; end
    drv(1'b1, 1'b0);
    checks++;
    if (idx_a !== 2'd2 || sel_a !== 4'b1011) begin
      errors++;
      $display("FAIL pre_reset idx=%0d sel=%b want idx=2 sel=1011", idx_a, sel_a);
    end
    #1 rst_a_n = 1'b0;
    #1;
    checks++;
    if (sel_a !== 4'hF || idx_a !== 2'd0 || blank_a !== 1'b1) begin
      errors++;
      $display("FAIL async_reset sel=%b idx=%0d blank=%b want sel=1111 idx=0 blank=1", sel_a, idx_a, blank_a);
    end
    @(negedge clk);
    rst_a_n = 1'b1;
    n_a = 0;
    for (int c = 0; c <= 5; c++) begin
      drv(1'b1, 1'b0);
      checks++;
      if (idx_a !== 2'(m_idx(n_a, 5, 4)) || st_a !== m_tick(n_a, 5, 1'b1) ||
          blank_a !== m_blank(n_a, 5, 1, 1'b1)) begin
        errors++;
        $display("FAIL post_reset cyc%0d idx=%0d st=%b blank=%b want idx=%0d st=%b blank=%b", c, idx_a,
                 st_a, blank_a, m_idx(n_a, 5, 4), m_tick(n_a, 5, 1'b1), m_blank(n_a, 5, 1, 1'b1));
      end
      clk_edge;
    end
  endtask

  task automatic test_wrap_hold;
    logic e;
    reset_a;
    for (int c = 0; c < 4; c++) begin drv(1'b1, 1'b0); clk_edge; end
    for (int c = 0; c < 3; c++) begin
      e = (c != 0);
      drv(e, 1'b0);
      checks++;
      if (st_a !== m_tick(n_a, 5, e) || idx_a !== 2'(m_idx(n_a, 5, 4))) begin
        errors++;
        $display("FAIL wrap_hold step%0d st=%b idx=%0d want st=%b idx=%0d", c, st_a, idx_a,
                 m_tick(n_a, 5, e), m_idx(n_a, 5, 4));
      end
      clk_edge;
    end
  endtask

  task automatic test_small_config;
    logic [2:0] exp_seq [7];
    exp_seq = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    reset_b;
    for (int c = 0; c < 7; c++) begin
      drv(1'b0, 1'b1);
      checks++;
      if (sel_b !== exp_seq[c] || blank_b !== 1'b0 || idx_b === 2'd3) begin
        errors++;
        $display("FAIL small_cfg cyc%0d sel=%b blank=%b idx=%0d want sel=%b blank=0 idx<3", c, sel_b,
                 blank_b, idx_b, exp_seq[c]);
      end
      clk_edge;
    end
  endtask

  task automatic test_random;
    logic ea, eb;
    reset_a;
    reset_b;
    for (int c = 0; c < 400; c++) begin
      ea = ($urandom_range(0, 3) != 0);
      eb = ($urandom_range(0, 3) != 0);
      drv(ea, eb);
      checks++;
      if (idx_a !== 2'(m_idx(n_a, 5, 4)) || sel_a !== 4'(m_sel(n_a, 5, 4, 1, ea, 1'b1)) ||
          blank_a !== m_blank(n_a, 5, 1, ea) || st_a !== m_tick(n_a, 5, ea) ||
          ft_a !== m_frame(n_a, 5, 4, ea)) begin
        errors++;
        $display("FAIL random_a cyc%0d idx=%0d sel=%b blank=%b st=%b ft=%b want %0d %b %b %b %b", c,
                 idx_a, sel_a, blank_a, st_a, ft_a, m_idx(n_a, 5, 4), 4'(m_sel(n_a, 5, 4, 1, ea, 1'b1)),
                 m_blank(n_a, 5, 1, ea), m_tick(n_a, 5, ea), m_frame(n_a, 5, 4, ea));
      end
      checks++;
      if (idx_b !== 2'(m_idx(n_b, 2, 3)) || sel_b !== 3'(m_sel(n_b, 2, 3, 0, eb, 1'b0)) ||
          blank_b !== m_blank(n_b, 2, 0, eb) || st_b !== m_tick(n_b, 2, eb) ||
          ft_b !== m_frame(n_b, 2, 3, eb)) begin
        errors++;
        $display("FAIL random_b cyc%0d idx=%0d sel=%b blank=%b st=%b ft=%b want %0d %b %b %b %b", c,
                 idx_b, sel_b, blank_b, st_b, ft_b, m_idx(n_b, 2, 3), 3'(m_sel(n_b, 2, 3, 0, eb, 1'b0)),
                 m_blank(n_b, 2, 0, eb), m_tick(n_b, 2, eb), m_frame(n_b, 2, 3, eb));
      end
      if ($urandom_range(0, 59) == 0) begin
        rst_a_n = 1'b0;
        #1;
        checks++;
        if (sel_a !== 4'hF || idx_a !== 2'd0 || st_a !== 1'b0) begin
          errors++;
          $display("FAIL random_rst sel=%b idx=%0d st=%b want 1111 0 0", sel_a, idx_a, st_a);
        end
        clk_edge;
        rst_a_n = 1'b1;
        n_a = 0;
      end else begin
        clk_edge;
      end
    end
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    test_reset;
    test_first_slot;
    test_frame;
    test_freeze;
    test_async_reset;
    test_wrap_hold;
    test_small_config;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
